// File: rtl/lsu_ctrl.sv
// lsu_ctrl: RV32I load/store sequencer in front of a word-wide memory with a
// combinational read port. Loads read and extend one lane; SB/SH perform a
// read-modify-write; SW writes straight through. Illegal codes answer with an
// error response and never touch memory.
// Optional feature: define LSU_MISALIGN_CHECK_EN to fault misaligned half/word
// accesses; without it the low offset bits are ignored (forced aligned).
module lsu_ctrl #(
   parameter int ADDR_W = 8
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_func3,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_din,
   output logic              mem_wren,
   output logic [2:0]        mem_func3,
   input  logic [31:0]       mem_dout
);

   typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

   state_t              state;
   logic                we_q;
   logic [2:0]          f3_q;
   logic [ADDR_W+1:0]   addr_q;
   logic [31:0]         wdata_q;
   logic [31:0]         rbuf;

   logic                accept;
   logic                illegal;
   logic                misalign;
   logic [7:0]          byte_sel;
   logic [15:0]         half_sel;
   logic [31:0]         ld_data;
   logic [31:0]         st_word;
   logic                unused_addr;

   // Address bits above the memory reach do not select anything.
   assign unused_addr = ^req_addr[31:ADDR_W+2];

   assign accept    = req_valid && (state == IDLE);
   assign req_ready = (state == IDLE);
   assign mem_addr  = addr_q[ADDR_W+1:2];
   assign mem_func3 = 3'b010;

   // Write port is decoded from the state so an async reset drops it at once.
   assign mem_wren  = (state == WR);
   assign mem_din   = (state == WR) ? st_word : 32'h0;

   // Legal codes: loads 000/001/010/100/101, stores 000/001/010.
   always_comb begin
      illegal = 1'b0;
      if (req_we)
         illegal = (req_func3 > 3'b010);
      else
         illegal = (req_func3 == 3'b011) || (req_func3 == 3'b110) || (req_func3 == 3'b111);
   end

   // Misalignment fault, only when the check is built in.
   always_comb begin
      misalign = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
      case (req_func3[1:0])
         2'b01:   misalign = req_addr[0];
         2'b10:   misalign = (req_addr[1:0] != 2'b00);
         default: misalign = 1'b0;
      endcase
`endif
   end

   // Lane select and extension of the word being read in RD.
   always_comb begin
      byte_sel = mem_dout[{addr_q[1:0], 3'b000} +: 8];
      half_sel = addr_q[1] ? mem_dout[31:16] : mem_dout[15:0];
      case (f3_q)
         3'b000:  ld_data = {{24{byte_sel[7]}}, byte_sel};
         3'b001:  ld_data = {{16{half_sel[15]}}, half_sel};
         3'b100:  ld_data = {24'h0, byte_sel};
         3'b101:  ld_data = {16'h0, half_sel};
         default: ld_data = mem_dout;
      endcase
   end

   // Store word: SW passes wdata through, SB/SH merge into the read buffer.
   always_comb begin
      st_word = rbuf;
      case (f3_q[1:0])
         2'b00: st_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
         2'b01: begin
            if (addr_q[1])
               st_word[31:16] = wdata_q[15:0];
            else
               st_word[15:0]  = wdata_q[15:0];
         end
         default: st_word = wdata_q;
      endcase
   end

   // Request FSM with registered response fields.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state      <= IDLE;
         we_q       <= 1'b0;
         f3_q       <= 3'b000;
         addr_q     <= '0;
         wdata_q    <= 32'h0;
         rbuf       <= 32'h0;
         resp_valid <= 1'b0;
         resp_rdata <= 32'h0;
         resp_err   <= 1'b0;
      end else begin
         resp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  we_q    <= req_we;
                  f3_q    <= req_func3;
                  addr_q  <= req_addr[ADDR_W+1:0];
                  wdata_q <= req_wdata;
                  if (illegal || misalign) begin
                     state      <= RESP;
                     resp_valid <= 1'b1;
                     resp_rdata <= 32'h0;
                     resp_err   <= 1'b1;
                  end else if (req_we && (req_func3 == 3'b010))
                     state <= WR;
                  else
                     state <= RD;
               end
            end
            RD: begin
               rbuf <= mem_dout;
               if (we_q)
                  state <= WR;
               else begin
                  state      <= RESP;
                  resp_valid <= 1'b1;
                  resp_rdata <= ld_data;
                  resp_err   <= 1'b0;
               end
            end
            WR: begin
               state      <= RESP;
               resp_valid <= 1'b1;
               resp_rdata <= 32'h0;
               resp_err   <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed and random load/store traffic against a byte-level
// reference model of the RV32I access rules and a behavioural memory.
module tb_lsu_ctrl;

   localparam int ADDR_W = 8;
   localparam int DEPTH  = 1 << ADDR_W;

   logic              clock = 1'b0;
   logic              resetn;
   logic              req_valid, req_ready, req_we;
   logic [2:0]        req_func3;
   logic [31:0]       req_addr, req_wdata;
   logic              resp_valid, resp_err;
   logic [31:0]       resp_rdata;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_din, mem_dout;
   logic              mem_wren;
   logic [2:0]        mem_func3;

   logic [31:0] mem     [DEPTH];
   logic [31:0] exp_mem [DEPTH];

   int nvec = 0;
   int nerr = 0;

   lsu_ctrl #(.ADDR_W(ADDR_W)) dut (
      .clock(clock), .resetn(resetn),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_addr(mem_addr), .mem_din(mem_din), .mem_wren(mem_wren),
      .mem_func3(mem_func3), .mem_dout(mem_dout)
   );

   always #5 clock = ~clock;

   assign mem_dout = mem[mem_addr];

   // Behavioural memory: word 5 holds the reference pattern, the rest random.
   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = (i == 5) ? 32'h8001_7F80 : $urandom;
      forever begin
         @(posedge clock);
         if (mem_wren) mem[mem_addr] <= mem_din;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: byte-array view of the access rules; updates exp_mem on stores.
   task automatic model(input bit we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output bit err, output logic [31:0] rd,
                        output int lat, output bit wr, output logic [31:0] nword);
      int size, idx, w;
      logic [7:0] b [4];
      longint unsigned v;
      w    = int'((a >> 2) & (DEPTH - 1));
      size = 1 << f3[1:0];
      idx  = int'(a[1:0]);
      if (we) err = (f3 > 3'd2);
      else    err = !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
`ifdef LSU_MISALIGN_CHECK_EN
      if (!err && (idx % size) != 0) err = 1'b1;
`endif
      if (!err) idx = idx - (idx % size);
      for (int i = 0; i < 4; i++) b[i] = exp_mem[w][8*i +: 8];
      rd = 32'h0; wr = 1'b0; nword = exp_mem[w]; lat = 1;
      if (err) lat = 1;
      else if (!we) begin
         v = 0;
         for (int i = 0; i < size; i++) v = v | (longint'(b[idx+i]) << (8*i));
         if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~((64'd1 << (8*size)) - 1);
         rd  = v[31:0];
         lat = 2;
      end else begin
         for (int i = 0; i < size; i++) b[idx+i] = wd[8*i +: 8];
         nword = {b[3], b[2], b[1], b[0]};
         wr  = 1'b1;
         lat = (size == 4) ? 2 : 3;
         exp_mem[w] = nword;
      end
   endtask

   // One transaction, started at a negedge; optional noise on the request bus while busy.
   task automatic do_req(input bit we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input bit noise);
      bit e_err, e_wr, got;
      logic [31:0] e_rd, e_word, din_seen;
      int e_lat, cyc, nwr, n, widx;
      model(we, f3, a, wd, e_err, e_rd, e_lat, e_wr, e_word);
      widx = int'((a >> 2) & (DEPTH - 1));
      n = 0;
      while (!req_ready && n < 20) begin @(negedge clock); n++; end
      chk("ready_wait", req_ready, 1);
      req_valid = 1; req_we = we; req_func3 = f3; req_addr = a; req_wdata = wd;
      @(posedge clock); #1;
      req_valid = 0;
      cyc = 0; got = 0; nwr = 0; din_seen = 32'h0;
      while (!got && cyc < 10) begin
         @(negedge clock);
         cyc++;
         if (mem_wren) begin nwr++; din_seen = mem_din; end
         if (resp_valid) got = 1;
         else if (noise) begin
            req_valid = 1'($urandom_range(0, 1)); req_we = 1'($urandom_range(0, 1));
            req_func3 = 3'($urandom_range(0, 7)); req_addr = $urandom; req_wdata = $urandom;
         end
      end
      req_valid = 0;
      chk("latency", got ? cyc : -1, e_lat);
      chk("resp_err", resp_err, e_err);
      chk("resp_rdata", resp_rdata, e_rd);
      chk("wren_count", nwr, e_wr);
      if (e_wr) chk("mem_din", din_seen, e_word);
      @(negedge clock);
      chk("resp_pulse", resp_valid, 0);
      chk("idle_ready", req_ready, 1);
      chk("rdata_held", resp_rdata, e_rd);
      chk("mem_word", mem[widx], exp_mem[widx]);
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] old;
      resetn = 0; req_valid = 0; req_we = 0; req_func3 = 0; req_addr = 0; req_wdata = 0;
      #1;
      for (int i = 0; i < DEPTH; i++) exp_mem[i] = mem[i];
      #11;
      chk("rst_ready", req_ready, 1);
      chk("rst_valid", resp_valid, 0);
      chk("rst_rdata", resp_rdata, 0);
      chk("rst_err", resp_err, 0);
      chk("rst_wren", mem_wren, 0);
      chk("rst_din", mem_din, 0);
      chk("rst_addr", mem_addr, 0);
      chk("mem_func3", mem_func3, 3'b010);
      @(negedge clock); resetn = 1;
      @(negedge clock);
      chk("post_rst_ready", req_ready, 1);

      // Reference word 5 = 8001_7F80: byte/half/word loads both signednesses
      do_req(0, 3'b000, 32'h14, 0, 0);
      do_req(0, 3'b100, 32'h14, 0, 0);
      do_req(0, 3'b000, 32'h15, 0, 0);
      do_req(0, 3'b001, 32'h16, 0, 0);
      do_req(0, 3'b101, 32'h16, 0, 0);
      do_req(0, 3'b010, 32'h14, 0, 0);
      // SB read-modify-write, then SW and back-to-back LW
      do_req(1, 3'b000, 32'h16, 32'h0000_00AB, 0);
      do_req(0, 3'b010, 32'h14, 0, 0);
      do_req(1, 3'b010, 32'h08, 32'hDEAD_BEEF, 0);
      do_req(0, 3'b010, 32'h08, 0, 0);
      do_req(1, 3'b001, 32'h0A, 32'h1234_5678, 0);
      do_req(0, 3'b010, 32'h08, 0, 0);
      // Misaligned word load and illegal codes
      do_req(0, 3'b010, 32'h02, 0, 0);
      do_req(1, 3'b001, 32'h0B, 32'h0000_CAFE, 0);
      do_req(0, 3'b011, 32'h10, 0, 0);
      do_req(1, 3'b100, 32'h10, 32'hFFFF_FFFF, 0);

      // Reset in the middle of a write cycle
      old = mem[2];
      req_valid = 1; req_we = 1; req_func3 = 3'b010; req_addr = 32'h08; req_wdata = 32'h0BAD_F00D;
      @(posedge clock); #1;
      req_valid = 0;
      #1;
      chk("wr_active", mem_wren, 1);
      resetn = 0;
      #1;
      chk("rst_wr_wren", mem_wren, 0);
      chk("rst_wr_ready", req_ready, 1);
      chk("rst_wr_valid", resp_valid, 0);
      chk("rst_wr_din", mem_din, 0);
      @(posedge clock); #1;
      chk("rst_wr_mem", mem[2], old);
      @(negedge clock); resetn = 1;
      @(negedge clock);
      do_req(0, 3'b010, 32'h08, 0, 0);

      // Random traffic, some with bus noise while busy
      for (int t = 0; t < 300; t++)
         do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
                ($urandom_range(0, 3) == 0));

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
